// File: rtl/vslc_scan_io.sv
// -----------------------------------------------------------------------------
// vslc_scan_io -- process-image engine for the VSLC logic controller.
//
// This block owns the scan cycle. It does four jobs:
//   * A phase timer that divides clk into scans of SCAN_DIV clocks.
//   * An input path. Field inputs pass through a 2-flop synchroniser and a
//     per-channel debouncer. The result is latched into in_image at scan
//     start and held for the whole scan.
//   * A shadow output buffer. The core writes it at any time. It is copied
//     to out_image at scan end, if the core reported done for that scan.
//   * A scan-overrun watchdog. It trips a sticky fault after WDOG_SCANS
//     missed commits in a row. On a trip, out_image is forced to the safe
//     all-zero state until reset.
//
// Optional build macro:
//   VSLC_SCAN_EDGE_EN  Build the per-scan rising/falling edge registers
//                      in_rise / in_fall. When the macro is undefined, both
//                      ports are tied to zero.
//
// Parameters:
//   IN_W        input channel count
//   OUT_W       output channel count
//   SCAN_DIV    clocks per scan (even, >= 4)
//   DEB_CNT     stable clocks needed before a debounced bit changes (>= 1)
//   WDOG_SCANS  consecutive overrun scans that trip the fault (>= 1)
//
// Ports:
//   clk             system clock
//   rst_n           synchronous active-low reset
//   ena             scan enable; 0 freezes the timer, the scan state and
//                   both images
//   raw_in          asynchronous field inputs
//   in_image        input image, stable for the whole scan
//   core_out        core output write data
//   core_we         writes core_out into the shadow buffer
//   core_done       core finished evaluating this scan
//   out_image       committed output image
//   scan_start      one-cycle pulse at the start of each scan
//   scan_cycle_clk  50% duty scan clock
//   scan_count      scan counter; wraps at 16 bits
//   overrun         sticky: at least one commit was missed
//   fault           sticky watchdog trip
//   in_rise         bits that rose between the previous and the current image
//   in_fall         bits that fell between the previous and the current image
// -----------------------------------------------------------------------------
module vslc_scan_io #(
  parameter int IN_W       = 8,
  parameter int OUT_W      = 8,
  parameter int SCAN_DIV   = 16,
  parameter int DEB_CNT    = 2,
  parameter int WDOG_SCANS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [IN_W-1:0]  raw_in,
  output logic [IN_W-1:0]  in_image,
  input  logic [OUT_W-1:0] core_out,
  input  logic             core_we,
  input  logic             core_done,
  output logic [OUT_W-1:0] out_image,
  output logic             scan_start,
  output logic             scan_cycle_clk,
  output logic [15:0]      scan_count,
  output logic             overrun,
  output logic             fault,
  output logic [IN_W-1:0]  in_rise,
  output logic [IN_W-1:0]  in_fall
);

  // ---------------------------------------------------------------------------
  // Derived widths and constants
  // ---------------------------------------------------------------------------
  localparam int PH_W  = $clog2(SCAN_DIV);
  localparam int DEB_W = (DEB_CNT > 1) ? $clog2(DEB_CNT + 1) : 1;
  localparam int WD_W  = $clog2(WDOG_SCANS + 1);

  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(SCAN_DIV - 1);
  localparam logic [PH_W-1:0]  PH_HALF  = PH_W'(SCAN_DIV / 2);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CNT - 1);
  localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(WDOG_SCANS);
  localparam logic [WD_W-1:0]  WD_TRIP  = WD_W'(WDOG_SCANS - 1);

  // ---------------------------------------------------------------------------
  // Input synchroniser and debouncer (runs regardless of ena)
  // ---------------------------------------------------------------------------
  logic [IN_W-1:0]            sync1;
  logic [IN_W-1:0]            sync2;
  logic [IN_W-1:0]            deb;
  logic [IN_W-1:0][DEB_W-1:0] deb_cnt;

  // A raw change is captured by sync1 on edge 1 and reaches sync2 on edge 2.
  // The counter then takes DEB_CNT further edges. The update fires on the
  // edge where the count would reach DEB_CNT, so a held change shows up on
  // deb exactly 2+DEB_CNT edges after it arrives. A shorter glitch makes
  // sync2 equal deb again first, which clears the counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1   <= '0;
      sync2   <= '0;
      deb     <= '0;
      // NOTE: the debounce counters are cleared explicitly on reset, like
      // every other register. A stale count left over from before reset
      // could otherwise let a short glitch through once reset is released.
      deb_cnt <= '0;
    end else begin
      // NOTE: sequential state is written only with non-blocking
      // assignments. That way sync2 takes the *old* sync1 on this edge,
      // which makes this a real two-flop chain.
      sync1 <= raw_in;
      sync2 <= sync1;
      for (int i = 0; i < IN_W; i++) begin
        if (sync2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          deb[i]     <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scan events
  // ---------------------------------------------------------------------------
  logic [PH_W-1:0] phase;
  logic            start_edge;
  logic            commit_edge;

  assign start_edge  = ena && (phase == '0);
  assign commit_edge = ena && (phase == PH_LAST);

  // ---------------------------------------------------------------------------
  // Phase timer, scan clock, scan counter and input image
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase          <= '0;
      scan_start     <= 1'b0;
      scan_cycle_clk <= 1'b0;
      scan_count     <= '0;
      in_image       <= '0;
    end else begin
      // scan_start is a registered pulse. It drops on any edge that is not
      // a scan start, including every edge while ena is low.
      scan_start <= start_edge;
      if (ena) begin
        phase <= (phase == PH_LAST) ? '0 : phase + PH_W'(1);
        // The clock is registered from the phase before the edge. Phases
        // 0..SCAN_DIV/2-1 therefore give a high level that starts in the
        // same cycle as the scan_start pulse.
        scan_cycle_clk <= (phase < PH_HALF);
      end
      if (start_edge) begin
        in_image   <= deb;
        scan_count <= scan_count + 16'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Shadow buffer and done flag
  // ---------------------------------------------------------------------------
  logic [OUT_W-1:0] shadow;
  logic             done_flag;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow    <= '0;
      done_flag <= 1'b0;
    end else begin
      if (core_we) begin
        shadow <= core_out;
      end
      // Clearing at scan start has priority. A core_done that lands on the
      // scan-start edge belongs to the previous scan and is dropped.
      if (start_edge) begin
        done_flag <= 1'b0;
      end else if (core_done) begin
        done_flag <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Commit and overrun watchdog
  // ---------------------------------------------------------------------------
  logic            done_now;
  logic [WD_W-1:0] ovr_cnt;

  assign done_now = done_flag || core_done;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_image <= '0;
      ovr_cnt   <= '0;
      overrun   <= 1'b0;
      fault     <= 1'b0;
    end else if (fault) begin
      // Safe state: outputs stay off and commits are ignored until reset.
      out_image <= '0;
    end else if (commit_edge) begin
      if (done_now) begin
        // shadow holds its pre-edge value here. A core write on this same
        // edge lands in shadow and goes out with the next commit.
        out_image <= shadow;
        ovr_cnt   <= '0;
      end else begin
        overrun <= 1'b1;
        if (ovr_cnt != WD_MAX) begin
          ovr_cnt <= ovr_cnt + WD_W'(1);
        end
        if (ovr_cnt == WD_TRIP) begin
          fault     <= 1'b1;
          out_image <= '0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Optional per-scan edge detection
  // ---------------------------------------------------------------------------
`ifdef VSLC_SCAN_EDGE_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_rise <= '0;
      in_fall <= '0;
    end else if (start_edge) begin
      // in_image still holds the previous scan's image on this edge.
      in_rise <= deb & ~in_image;
      in_fall <= ~deb & in_image;
    end
  end
`else
  assign in_rise = '0;
  assign in_fall = '0;
`endif

endmodule

// File: tb/tb_vslc_scan_io.sv
// -----------------------------------------------------------------------------
// tb_vslc_scan_io -- self-checking bench for vslc_scan_io (default parameters).
// The scan timing comes from a vector table. Debounce, commit, watchdog,
// freeze and reset behaviour are covered by directed sequences. Each
// sequence is keyed to the number of enabled clock edges since reset
// (ena_edges). With default parameters, a scan starts on edge 16n+1 and
// commits on edge 16n.
// -----------------------------------------------------------------------------
module tb_vslc_scan_io;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic [7:0]  raw_in;
  logic [7:0]  in_image;
  logic [7:0]  core_out;
  logic        core_we;
  logic        core_done;
  logic [7:0]  out_image;
  logic        scan_start;
  logic        scan_cycle_clk;
  logic [15:0] scan_count;
  logic        overrun;
  logic        fault;
  logic [7:0]  in_rise;
  logic [7:0]  in_fall;

`ifdef VSLC_SCAN_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int ena_edges = 0;

  vslc_scan_io dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ena            (ena),
    .raw_in         (raw_in),
    .in_image       (in_image),
    .core_out       (core_out),
    .core_we        (core_we),
    .core_done      (core_done),
    .out_image      (out_image),
    .scan_start     (scan_start),
    .scan_cycle_clk (scan_cycle_clk),
    .scan_count     (scan_count),
    .overrun        (overrun),
    .fault          (fault),
    .in_rise        (in_rise),
    .in_fall        (in_fall)
  );

  always #5 clk = ~clk;

  // Reference position within the scan: enabled edges since reset.
  always @(posedge clk) begin
    if (!rst_n) ena_edges <= 0;
    else if (ena) ena_edges <= ena_edges + 1;
  end

  typedef struct {
    int          k;
    logic        start;
    logic        sclk;
    logic [15:0] count;
  } tvec_t;

  tvec_t tab[34];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t, edge %0d)", name, act, exp, $time, ena_edges);
    end
  endtask

  // Move to the falling edge that follows enabled edge n.
  task automatic go_to(input int n);
    int guard = 0;
    while (ena_edges < n) begin
      @(negedge clk);
      guard++;
      if (guard > 2000) begin
        n_tests++;
        n_fail++;
        $display("FAIL go_to timeout: at edge %0d, expected to reach %0d", ena_edges, n);
        return;
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " out_image"}, out_image, 0);
    check({tag, " in_image"}, in_image, 0);
    check({tag, " scan_count"}, scan_count, 0);
    check({tag, " scan_start"}, scan_start, 0);
    check({tag, " scan_cycle_clk"}, scan_cycle_clk, 0);
    check({tag, " overrun"}, overrun, 0);
    check({tag, " fault"}, fault, 0);
    check({tag, " in_rise"}, in_rise, 0);
    check({tag, " in_fall"}, in_fall, 0);
  endtask

  initial begin
    // Expected scan timing after k enabled edges. The phase is k mod 16.
    // The pulse appears after the phase-0 edge, the clock is high for
    // phases 1..8, and the count rises at every scan start.
    for (int i = 0; i < 34; i++) begin
      tab[i].k     = i;
      tab[i].start = ((i % 16) == 1);
      tab[i].sclk  = ((i % 16) >= 1) && ((i % 16) <= 8);
      tab[i].count = 16'((i + 15) / 16);
    end

    rst_n = 1'b0; ena = 1'b0; raw_in = 8'h00;
    core_out = 8'h00; core_we = 1'b0; core_done = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");

    // ---- Scan timing table (core_done held so no overrun) ----
    rst_n = 1'b1; ena = 1'b1; core_done = 1'b1;
    for (int i = 0; i < 34; i++) begin
      go_to(tab[i].k);
      check($sformatf("scan_start k=%0d", tab[i].k), scan_start, tab[i].start);
      check($sformatf("scan_cycle_clk k=%0d", tab[i].k), scan_cycle_clk, tab[i].sclk);
      check($sformatf("scan_count k=%0d", tab[i].k), scan_count, tab[i].count);
    end
    check("overrun after timing", overrun, 0);

    // ---- Debounce latency versus scan start ----
    go_to(45); raw_in = 8'hA5;            // debounced on edge 49: one too late
    go_to(49);
    check("in_image late change", in_image, 8'h00);
    go_to(65);
    check("in_image A5", in_image, 8'hA5);
    check("in_rise A5", in_rise, EDGE_EN ? 8'hA5 : 8'h00);
    check("in_fall A5", in_fall, 8'h00);
    go_to(76); raw_in = 8'hFF;            // debounced on edge 80: just in time
    go_to(81);
    check("in_image just in time", in_image, 8'hFF);
    check("in_rise FF", in_rise, EDGE_EN ? 8'h5A : 8'h00);
    go_to(82); raw_in = 8'hFE;            // one-cycle glitch on bit 0
    go_to(83); raw_in = 8'hFF;
    go_to(97);
    check("in_image glitch rejected", in_image, 8'hFF);
    check("in_rise steady", in_rise, 8'h00);
    check("in_fall steady", in_fall, 8'h00);

    // ---- Commit path ----
    go_to(100); raw_in = 8'h0F;
    go_to(112); core_done = 1'b0;
    go_to(113);
    check("in_image 0F", in_image, 8'h0F);
    check("in_fall 0F", in_fall, EDGE_EN ? 8'hF0 : 8'h00);
    go_to(114); core_we = 1'b1; core_out = 8'h3C;
    go_to(115); core_we = 1'b0; raw_in = 8'h3C;
    go_to(119); core_done = 1'b1;
    go_to(120); core_done = 1'b0;
    go_to(127);
    check("out_image before commit", out_image, 8'h00);
    go_to(128);
    check("out_image commit 3C", out_image, 8'h3C);
    check("overrun after good commit", overrun, 0);
    go_to(129);
    check("in_image 3C", in_image, 8'h3C);
    check("in_rise 0F->3C", in_rise, EDGE_EN ? 8'h30 : 8'h00);
    check("in_fall 0F->3C", in_fall, EDGE_EN ? 8'h03 : 8'h00);
    core_done = 1'b1;
    go_to(130); core_done = 1'b0;
    go_to(143); core_we = 1'b1; core_out = 8'h77;   // write on the commit edge
    go_to(144); core_we = 1'b0;
    check("same-edge write not committed", out_image, 8'h3C);
    go_to(159); core_done = 1'b1;                   // done only on the commit edge
    go_to(160); core_done = 1'b0;
    check("deferred write committed", out_image, 8'h77);
    check("overrun still clear", overrun, 0);

    // ---- Overrun watchdog ----
    go_to(175);
    check("overrun before first miss", overrun, 0);
    go_to(176);
    check("overrun after miss 1", overrun, 1);
    check("out_image held on miss", out_image, 8'h77);
    check("fault after miss 1", fault, 0);
    go_to(208);
    check("fault after miss 3", fault, 0);
    go_to(219); core_done = 1'b1;                   // good scan clears the count
    go_to(220); core_done = 1'b0;
    go_to(224);
    check("overrun sticky", overrun, 1);
    check("fault after recovery", fault, 0);
    go_to(272);
    check("fault after 3 more misses", fault, 0);
    check("out_image before trip", out_image, 8'h77);
    go_to(288);
    check("fault after 4 misses", fault, 1);
    check("out_image safe state", out_image, 8'h00);
    go_to(289); core_we = 1'b1; core_out = 8'h55; core_done = 1'b1;
    go_to(290); core_we = 1'b0;
    go_to(304);
    check("fault sticky", fault, 1);
    check("out_image held at 0", out_image, 8'h00);

    // ---- Reset clears fault; ena freeze ----
    rst_n = 1'b0; ena = 1'b0;
    @(negedge clk);
    check_all_zero("reset after fault");
    rst_n = 1'b1; ena = 1'b1;
    go_to(1);
    check("scan_start after reset", scan_start, 1);
    check("in_image debounce cleared", in_image, 8'h00);
    ena = 1'b0;
    @(negedge clk);
    check("scan_start dropped by ena=0", scan_start, 0);
    repeat (2) @(negedge clk);
    check("frozen scan_count", scan_count, 16'd1);
    ena = 1'b1;
    go_to(7);
    ena = 1'b0; core_we = 1'b1; core_out = 8'h42;   // shadow write while frozen
    @(negedge clk);
    core_we = 1'b0;
    repeat (19) @(negedge clk);
    check("freeze scan_count", scan_count, 16'd1);
    check("freeze scan_cycle_clk", scan_cycle_clk, 1);
    check("freeze scan_start", scan_start, 0);
    check("freeze out_image", out_image, 8'h00);
    ena = 1'b1;
    go_to(15);
    check("no early commit", out_image, 8'h00);
    go_to(16);
    check("resumed commit", out_image, 8'h42);
    check("resumed scan_count", scan_count, 16'd1);
    go_to(17);
    check("next scan_start", scan_start, 1);
    check("next scan_count", scan_count, 16'd2);
    check("in_image after reset", in_image, 8'h3C);

    // ---- Reset mid-scan ----
    go_to(19); core_we = 1'b1; core_out = 8'h99;
    go_to(20); core_we = 1'b0;
    go_to(21);
    check("scan clock high before abort", scan_cycle_clk, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("mid-scan reset");
    rst_n = 1'b1;
    go_to(16);
    check("shadow cleared by reset", out_image, 8'h00);
    check("no overrun after reset", overrun, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vslc_scan_io.md
Name: vslc_scan_io

Overview:
- Parametrised process-image engine for the VSLC logic controller.
- Owns the scan cycle: a phase timer, a synchronised and debounced input image latched at scan start, and a shadow output buffer that the core writes and that is committed at scan end.
- Provides a scan-overrun watchdog with a safe-state fault.
- Sits between the pad I/O and the VSLC core; generalises the fixed 8-bit, scan-clock-only scheme to N inputs and M outputs with timing supervision.

Parameters:
- IN_W, 8, input channel count.
- OUT_W, 8, output channel count.
- SCAN_DIV, 16, clocks per scan period (even, >=4).
- DEB_CNT, 2, consecutive stable clocks before a debounced bit changes (>=1).
- WDOG_SCANS, 4, consecutive overrun scans that trip the fault (>=1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; synchronous, active-low.
- ena  in  1  scan enable; 0 freezes the timer, state and images.
- raw_in  in  IN_W  asynchronous field inputs.
- in_image  out  IN_W  input image, stable for the whole scan.
- core_out  in  OUT_W  core output write data.
- core_we  in  1  writes core_out into the shadow buffer.
- core_done  in  1  core finished evaluating this scan.
- out_image  out  OUT_W  committed output image.
- scan_start  out  1  one-cycle pulse at the start of each scan.
- scan_cycle_clk  out  1  50% duty scan clock.
- scan_count  out  16  scan counter.
- overrun  out  1  sticky: at least one missed commit.
- fault  out  1  sticky watchdog trip.
- in_rise  out  IN_W  see Optional Feature.
- in_fall  out  IN_W  see Optional Feature.

Behaviour:
- Reset: all registers clear on a clk edge with rst_n=0. This includes sync flops, debounce counters, debounced bits, phase, in_image, shadow, out_image, scan_count, the done flag, the overrun counter, overrun, fault, scan_start and scan_cycle_clk. Reset asserted mid-scan aborts the scan; no commit occurs.
- Input path: 2-flop synchroniser per channel, then a per-channel counter.
  - The counter increments while the synced bit differs from the debounced bit, and clears when they are equal.
  - When the count reaches DEB_CNT, the debounced bit takes the synced value and the counter clears.
  - A raw change held stable appears on the debounced bit exactly 2+DEB_CNT edges later.
  - A glitch shorter than DEB_CNT clocks never appears.
  - The debounce path runs regardless of ena.
- Phase timer: counts 0..SCAN_DIV-1 and wraps, only while ena=1. Counter value is 0 after reset.
- Scan start: on an edge with ena=1 and phase==0:
  - in_image <= debounced bits;
  - done flag cleared;
  - scan_count increments (wraps 0xFFFF->0);
  - scan_start=1 for the following cycle only.
- scan_cycle_clk: registered; high for the SCAN_DIV/2 cycles that begin with the scan_start cycle, low for the rest of the scan.
- Shadow buffer: core_we=1 at any edge loads core_out into shadow, including after core_done. core_done=1 sets the done flag.
- Commit: on an edge with ena=1 and phase==SCAN_DIV-1.
  - Done is the done flag OR core_done on that edge.
  - If done: out_image <= shadow value before any same-edge write (a same-edge write is kept for the next commit); overrun counter clears.
  - If not done: out_image holds; overrun <= 1; overrun counter increments, saturating at WDOG_SCANS.
  - When the counter reaches WDOG_SCANS: fault <= 1, out_image forced to 0 and held at 0, commits ignored until reset.
- ena=0: no state advances, outputs hold, scan_start=0. core_we still writes shadow.
- Simultaneous events: commit and scan start never coincide (SCAN_DIV>=4). The done-flag set from core_done at the scan-start edge is lost, because the clear wins.

Optional Feature:
- Macro: VSLC_SCAN_EDGE_EN.
- Defined: at each scan start, in_rise <= new image & ~previous in_image, and in_fall <= ~new image & previous in_image. Both hold for the whole scan and reset to 0.
- Undefined: in_rise and in_fall are tied to 0 and no edge registers are built.

Test Plan:
- Reset then ena=1 with defaults -> scan_start pulses every 16 cycles; scan_cycle_clk high 8 cycles, low 8; scan_count 0,1,2…
- raw_in 0x00->0xA5, held -> debounced value 0xA5 after 4 edges; in_image=0xA5 from the next scan_start. A 1-cycle pulse on bit 0 -> never seen.
- core_we with 0x3C, then core_done in the same scan -> out_image=0x3C after the phase-15 edge. core_we 0x77 at the commit edge -> out_image stays 0x3C, then 0x77 one scan later.
- No core_done for 4 scans with out_image=0x3C -> overrun=1 after scan 1, out_image held 0x3C; fault=1 and out_image=0x00 after scan 4; later core_done has no effect until rst_n low.
- ena=0 at phase 7 for 20 cycles -> all outputs frozen; resume completes the scan 9 cycles later. rst_n low at phase 10 -> all outputs 0 on the next edge.
- With VSLC_SCAN_EDGE_EN, in_image 0x0F->0x3C across scans -> in_rise=0x30, in_fall=0x03 for that scan.
